// File: rtl/gray_sobel_edge_pkg.sv
// Shared image-pipeline constants and small arithmetic helpers for the Sobel stage.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Pixel and gradient widths are fixed here so all stages agree on them.
package gray_sobel_edge_pkg;

    localparam int PIX_W     = 8;
    localparam int SOBEL_W   = 11;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    function automatic logic signed [SOBEL_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
        return $signed({{(SOBEL_W-PIX_W){1'b0}}, p});
    endfunction

    // Gradients never reach -1024, so the negation cannot overflow.
    function automatic logic [SOBEL_W-1:0] abs_s(input logic signed [SOBEL_W-1:0] v);
        return v[SOBEL_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/gray_sobel_edge_line_buffer.sv
// One-line pixel delay: returns the pixel written DEPTH accepts ago at the same column.
// Read is combinational from the current address; write lands on the clock edge when en=1.
// No flow control: holds its contents indefinitely while en=0.
module sobel_line_buffer #(
    parameter  int DEPTH = 640,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_dat = mem_q[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/gray_sobel_edge.sv
// Sobel |Gx|+|Gy| on a raster grayscale stream with saturated magnitude and edge flag.
// Fixed 3-cycle latency from an accepted pixel to its result; one result per accepted pixel.
// No backpressure: gaps on gray_in_en freeze the window and simply propagate as bubbles.
module gray_sobel_edge
    import gray_sobel_edge_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] gray_in,
    input  logic             gray_in_en,
    input  logic             frame_clr,
    input  logic [PIX_W-1:0] threshold,
    output logic [PIX_W-1:0] mag_out,
    output logic             edge_out,
    output logic             edge_out_en
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic signed [SOBEL_W-1:0] grad_t;

    logic          accept;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    pix_t          lb0_rd, lb1_rd;
    pix_t          win_q [3][3];
    pix_t          win_d [3][3];
    logic          vld1_q, vld1_d, bord1_q, bord1_d;
    grad_t         gx_q, gx_d, gy_q, gy_d;
    logic          vld2_q, bord2_q;
    logic [SOBEL_W-1:0] mag;
    pix_t          mag_out_q, mag_out_d;
    logic          edge_out_q, edge_out_d;
    logic          edge_out_en_q;

    // A frame_clr cycle never counts as a pixel, even with gray_in_en high.
    assign accept = gray_in_en && !frame_clr;

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk    (clk),
        .en     (accept),
        .addr   (x_q),
        .wr_dat (gray_in),
        .rd_dat (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk    (clk),
        .en     (accept),
        .addr   (x_q),
        .wr_dat (lb0_rd),
        .rd_dat (lb1_rd)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (accept) begin
            if (x_q == XW'(IMG_W-1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H-1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // S1: window shifts left on each accept; the first two columns/rows of a
    // frame still hold stale pixels, so they are flagged for masking in S3.
    always_comb begin
        win_d   = win_q;
        bord1_d = bord1_q;
        vld1_d  = accept;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = gray_in;
            bord1_d     = (x_q < XW'(2)) || (y_q < YW'(2));
        end
    end

    always_comb begin
        gx_d = (pix_ext(win_q[0][2]) + (pix_ext(win_q[1][2]) <<< 1) + pix_ext(win_q[2][2]))
             - (pix_ext(win_q[0][0]) + (pix_ext(win_q[1][0]) <<< 1) + pix_ext(win_q[2][0]));
        gy_d = (pix_ext(win_q[2][0]) + (pix_ext(win_q[2][1]) <<< 1) + pix_ext(win_q[2][2]))
             - (pix_ext(win_q[0][0]) + (pix_ext(win_q[0][1]) <<< 1) + pix_ext(win_q[0][2]));
    end

    assign mag = abs_s(gx_q) + abs_s(gy_q);

    always_comb begin
        mag_out_d  = '0;
        edge_out_d = 1'b0;
        if (vld2_q && !bord2_q) begin
            mag_out_d  = (mag > SOBEL_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
            edge_out_d = (mag >= {{(SOBEL_W-PIX_W){1'b0}}, threshold});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            win_q         <= '{default: '0};
            vld1_q        <= 1'b0;
            bord1_q       <= 1'b0;
            gx_q          <= '0;
            gy_q          <= '0;
            vld2_q        <= 1'b0;
            bord2_q       <= 1'b0;
            mag_out_q     <= '0;
            edge_out_q    <= 1'b0;
            edge_out_en_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            win_q         <= win_d;
            vld1_q        <= vld1_d;
            bord1_q       <= bord1_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            vld2_q        <= vld1_q;
            bord2_q       <= bord1_q;
            mag_out_q     <= mag_out_d;
            edge_out_q    <= edge_out_d;
            edge_out_en_q <= vld2_q;
        end
    end

    assign mag_out     = mag_out_q;
    assign edge_out    = edge_out_q;
    assign edge_out_en = edge_out_en_q;

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Directed bench for gray_sobel_edge on an 8x6 frame with a frame-level Sobel reference.
// Results are matched in order against a queue of expected values and emit cycles.
module tb_gray_sobel_edge;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gray_in = '0;
    logic       gray_in_en = 1'b0;
    logic       frame_clr = 1'b0;
    logic [7:0] threshold = '0;
    logic [7:0] mag_out;
    logic       edge_out;
    logic       edge_out_en;

    gray_sobel_edge #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_in     (gray_in),
        .gray_in_en  (gray_in_en),
        .frame_clr   (frame_clr),
        .threshold   (threshold),
        .mag_out     (mag_out),
        .edge_out    (edge_out),
        .edge_out_en (edge_out_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int edg;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   img [H][W];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_recv = 0;
    int   n_exp = 0;
    int   cycle_cnt = 0;
    int   thr_v = 0;
    int   bx = 0;
    int   by = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input int x, input int y, input int thr,
                                  output int m, output int e);
        int cx, cy, gx, gy, mg;
        if (x < 2 || y < 2) begin
            m = 0;
            e = 0;
        end else begin
            cx = x - 1;
            cy = y - 1;
            gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
            gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
            mg = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            m  = (mg > 255) ? 255 : mg;
            e  = (mg >= thr) ? 1 : 0;
        end
    endfunction

    always @(negedge clk) begin
        if (edge_out_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_en", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mag_out", int'(mag_out), e.mag);
                chk("edge_out", int'(edge_out), e.edg);
                chk("latency", cycle_cnt, e.cyc + 3);
                n_recv++;
            end
        end
    end

    task automatic send(input bit clr, input int gap);
        int m, e;
        exp_t ex;
        @(posedge clk); #1;
        gray_in    = 8'(img[by][bx]);
        gray_in_en = 1'b1;
        frame_clr  = clr;
        if (clr) begin
            bx = 0;
            by = 0;
        end else begin
            model(bx, by, thr_v, m, e);
            ex.mag = m;
            ex.edg = e;
            ex.cyc = cycle_cnt;
            exp_q.push_back(ex);
            n_exp++;
            if (bx == W-1) begin
                bx = 0;
                by = (by == H-1) ? 0 : by + 1;
            end else begin
                bx++;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            gray_in_en = 1'b0;
            frame_clr  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            gray_in_en = 1'b0;
            frame_clr  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        idle(4);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_count"}, n_recv, n_exp);
        n_recv = 0;
        n_exp  = 0;
    endtask

    task automatic run_frame(input int thr, input int gapmax);
        thr_v = thr;
        threshold = 8'(thr);
        for (int i = 0; i < W*H; i++) send(1'b0, (gapmax > 0) ? $urandom_range(gapmax, 1) : 0);
        idle(1);
    endtask

    task automatic set_img(input int kind);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0: img[y][x] = 100;
                    1: img[y][x] = (x < 4) ? 0 : 255;
                    default: img[y][x] = 10 * y;
                endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mag", int'(mag_out), 0);
        chk("rst_edge", int'(edge_out), 0);
        chk("rst_en", int'(edge_out_en), 0);
        rst_n = 1'b1;
        idle(2);

        set_img(0);
        run_frame(1, 0);
        chk("flat_pulses", n_recv + exp_q.size(), 48);
        drain("flat");

        set_img(1);
        run_frame(128, 0);
        drain("vstep");

        set_img(2);
        run_frame(80, 0);
        drain("ramp80");
        run_frame(81, 0);
        drain("ramp81");

        set_img(0);
        run_frame(1, 5);
        drain("flat_gaps");

        // Partial ramp frame into row 3, then reset with results in flight.
        set_img(2);
        thr_v = 80;
        threshold = 8'd80;
        for (int i = 0; i < 3*W + 5; i++) send(1'b0, 0);
        @(posedge clk); #1;
        gray_in_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_mag", int'(mag_out), 0);
        chk("midrst_en", int'(edge_out_en), 0);
        bx = 0;
        by = 0;
        n_recv = 0;
        n_exp = 0;
        idle(3);
        rst_n = 1'b1;
        run_frame(80, 0);
        drain("after_rst");

        // frame_clr coincident with the pixel at (5,2).
        set_img(2);
        for (int i = 0; i < 2*W + 5; i++) send(1'b0, 0);
        chk("fclr_pos_x", bx, 5);
        send(1'b1, 0);
        chk("fclr_first_border_exp", int'(bx == 0 && by == 0), 1);
        run_frame(80, 0);
        drain("fclr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
